i2c_bus_event_detector: RTL and testbench

Consumes the synchronized, debounced SCL and SDA lines and turns them into I2C bus events: START, STOP, SCL edges, and assembled 8-bit bytes with their acknowledge bit. It sits directly downstream of the per-line debounced synchronizers in the I2C controller. Its registered single-cycle pulses and byte outputs feed the controller's protocol FSM.

---
 rtl/i2c_pkg.sv | 12 +
 rtl/i2c_line_edge.sv | 33 +++
 rtl/i2c_bus_event_detector.sv | 128 ++++++++++++
 tb/tb_i2c_bus_event_detector.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bus event detector: FSM encoding, byte width
// and the level both bus lines idle at.
package i2c_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ACK  = 2'd2
  } i2c_state_e;

  localparam int   I2C_DATA_BITS  = 8;
  localparam logic I2C_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/i2c_line_edge.sv
// Previous-sample registers for SCL/SDA and combinational decode of SCL edges
// and START/STOP conditions; the parent registers the results.
module i2c_line_edge
  import i2c_pkg::*;
(
  input  logic fastClock,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic scl_prev, sda_prev;

  always_ff @(posedge fastClock) begin
    if (reset) begin
      scl_prev <= I2C_IDLE_LEVEL;
      sda_prev <= I2C_IDLE_LEVEL;
    end else begin
      scl_prev <= scl;
      sda_prev <= sda;
    end
  end

  // START/STOP need SCL high on both samples, so a simultaneous SCL/SDA
  // change only ever shows up as an SCL edge.
  assign scl_rise = !scl_prev && scl;
  assign scl_fall = scl_prev && !scl;
  assign start    = scl_prev && scl && sda_prev && !sda;
  assign stop     = scl_prev && scl && !sda_prev && sda;
endmodule

// File: rtl/i2c_bus_event_detector.sv
// Turns debounced SCL/SDA into registered bus events, received bytes and ACKs.
// Optional SCL-low bus timeout is built when I2C_BUS_TIMEOUT_EN is defined.
module i2c_bus_event_detector
  import i2c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       fastClock,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda,
  output logic       startDetected,
  output logic       stopDetected,
  output logic       sclRise,
  output logic       sclFall,
  output logic [7:0] rxByte,
  output logic       rxValid,
  output logic       ackBit,
  output logic       ackValid,
  output logic       busBusy,
  output logic       busTimeout
);
  localparam int BCW = $clog2(I2C_DATA_BITS);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic                     ev_rise, ev_fall, ev_start, ev_stop;
  logic                     timeout_hit;
  i2c_state_e               state;
  logic [BCW-1:0]           bit_count;
  logic [I2C_DATA_BITS-1:0] shift_reg;
  logic [I2C_DATA_BITS-1:0] shifted;

  i2c_line_edge u_edge (
    .fastClock (fastClock),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (ev_rise),
    .scl_fall  (ev_fall),
    .start     (ev_start),
    .stop      (ev_stop)
  );

  assign shifted = {shift_reg[I2C_DATA_BITS-2:0], sda};

`ifdef I2C_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_count;

  // Fires on the TIMEOUT_CYCLES-th consecutive SCL-low cycle of a transfer.
  assign timeout_hit = (state != ST_IDLE) && !scl &&
                       (to_count == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge fastClock) begin
    if (reset) begin
      to_count   <= '0;
      busTimeout <= 1'b0;
    end else begin
      busTimeout <= timeout_hit;
      if (state == ST_IDLE || scl || timeout_hit) to_count <= '0;
      else                                        to_count <= to_count + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign busTimeout  = 1'b0;
`endif

  always_ff @(posedge fastClock) begin
    if (reset) begin
      state         <= ST_IDLE;
      bit_count     <= '0;
      shift_reg     <= '0;
      startDetected <= 1'b0;
      stopDetected  <= 1'b0;
      sclRise       <= 1'b0;
      sclFall       <= 1'b0;
      rxByte        <= '0;
      rxValid       <= 1'b0;
      ackBit        <= 1'b0;
      ackValid      <= 1'b0;
      busBusy       <= 1'b0;
    end else begin
      startDetected <= 1'b0;
      stopDetected  <= 1'b0;
      rxValid       <= 1'b0;
      ackValid      <= 1'b0;
      sclRise       <= ev_rise;
      sclFall       <= ev_fall;
      // Timeout beats STOP beats START; bus conditions never coincide with SCL edges.
      if (timeout_hit) begin
        state   <= ST_IDLE;
        busBusy <= 1'b0;
      end else if (ev_stop) begin
        state        <= ST_IDLE;
        busBusy      <= 1'b0;
        stopDetected <= 1'b1;
      end else if (ev_start) begin
        state         <= ST_DATA;
        bit_count     <= '0;
        busBusy       <= 1'b1;
        startDetected <= 1'b1;
      end else if (ev_rise) begin
        case (state)
          ST_DATA: begin
            shift_reg <= shifted;
            bit_count <= bit_count + BCW'(1);
            if (bit_count == BCW'(I2C_DATA_BITS - 1)) begin
              rxByte  <= shifted;
              rxValid <= 1'b1;
              state   <= ST_ACK;
            end
          end
          ST_ACK: begin
            ackBit    <= sda;
            ackValid  <= 1'b1;
            bit_count <= '0;
            state     <= ST_DATA;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_bus_event_detector.sv
// Bench for i2c_bus_event_detector: transaction-level bus model checked every
// cycle, plus directed literal expectations per scenario.
module tb_i2c_bus_event_detector;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic       startDetected, stopDetected, sclRise, sclFall;
  logic [7:0] rxByte;
  logic       rxValid, ackBit, ackValid, busBusy, busTimeout;

  int n_checks = 0;
  int n_fail   = 0;

  i2c_bus_event_detector #(.TIMEOUT_CYCLES(TO)) dut (
    .fastClock     (clk),
    .reset         (rst),
    .scl           (scl),
    .sda           (sda),
    .startDetected (startDetected),
    .stopDetected  (stopDetected),
    .sclRise       (sclRise),
    .sclFall       (sclFall),
    .rxByte        (rxByte),
    .rxValid       (rxValid),
    .ackBit        (ackBit),
    .ackValid      (ackValid),
    .busBusy       (busBusy),
    .busTimeout    (busTimeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bits = -1 when no transfer is open, 0..7 data bits taken, 8 = awaiting ACK.
  int         m_bits = -1;
  int         m_acc  = 0;
  int         m_cnt  = 0;
  logic       m_pscl = 1'b1, m_psda = 1'b1;
  logic       e_start, e_stop, e_rise, e_fall, e_rxv, e_ack, e_ackv, e_busy, e_to;
  logic [7:0] e_byte;

  always @(posedge clk) begin
    logic rise, fall, st, sp, to;
    if (rst) begin
      {e_start, e_stop, e_rise, e_fall, e_rxv, e_ack, e_ackv, e_busy, e_to} = '0;
      e_byte = 8'h00;
      m_bits = -1; m_acc = 0; m_cnt = 0; m_pscl = 1'b1; m_psda = 1'b1;
    end else begin
      rise = !m_pscl && scl;
      fall = m_pscl && !scl;
      st   = m_pscl && scl && m_psda && !sda;
      sp   = m_pscl && scl && !m_psda && sda;
      to   = 1'b0;
      e_rise = rise; e_fall = fall;
      {e_start, e_stop, e_rxv, e_ackv, e_to} = '0;
`ifdef I2C_BUS_TIMEOUT_EN
      if (m_bits >= 0 && !scl) begin
        m_cnt++;
        if (m_cnt == TO) begin to = 1'b1; m_cnt = 0; end
      end else m_cnt = 0;
`endif
      if (to) begin
        e_to = 1'b1; m_bits = -1;
      end else if (sp) begin
        e_stop = 1'b1; m_bits = -1;
      end else if (st) begin
        e_start = 1'b1; m_bits = 0; m_acc = 0;
      end else if (rise && m_bits >= 0) begin
        if (m_bits < 8) begin
          m_acc = m_acc * 2 + int'(sda);
          m_bits++;
          if (m_bits == 8) begin e_byte = m_acc[7:0]; e_rxv = 1'b1; end
        end else begin
          e_ack = sda; e_ackv = 1'b1; m_bits = 0; m_acc = 0;
        end
      end
      e_busy = (m_bits >= 0);
      m_pscl = scl; m_psda = sda;
    end
  end

  // Per-cycle comparison and pulse counters.
  int   c_start = 0, c_stop = 0, c_rise = 0, c_rxv = 0, c_ackv = 0, c_to = 0;
  logic to_busy = 1'b1;

  always @(negedge clk) begin
    chk("cycle_outputs",
        {15'd0, startDetected, stopDetected, sclRise, sclFall, rxValid, rxByte,
         ackValid, ackBit, busBusy, busTimeout},
        {15'd0, e_start, e_stop, e_rise, e_fall, e_rxv, e_byte,
         e_ackv, e_ack, e_busy, e_to});
    c_start += int'(startDetected);
    c_stop  += int'(stopDetected);
    c_rise  += int'(sclRise);
    c_rxv   += int'(rxValid);
    c_ackv  += int'(ackValid);
    c_to    += int'(busTimeout);
    if (busTimeout) to_busy = busBusy;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda = 1'b1; tick(2);
    scl = 1'b1; tick(2);
    sda = 1'b0; tick(2);
    scl = 1'b0; tick(1);
  endtask

  task automatic bus_stop();
    sda = 1'b0; tick(2);
    scl = 1'b1; tick(2);
    sda = 1'b1; tick(2);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    if (glitch) begin
      sda = ~b; tick(1); sda = b; tick(1); sda = ~b; tick(1);
    end
    sda = b; tick(2);
    scl = 1'b1; tick(2);
    scl = 1'b0; tick(1);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic ack, input logic glitch);
    for (int i = 7; i >= 0; i--) send_bit(v[i], glitch);
    send_bit(ack, 1'b0);
  endtask

  initial begin
    int b_start, b_stop, b_rise, b_rxv, b_ackv, b_to;

    // Reset with idle lines
    tick(20);
    chk("reset_outputs",
        {15'd0, startDetected, stopDetected, sclRise, sclFall, rxValid, rxByte,
         ackValid, ackBit, busBusy, busTimeout}, 32'd0);
    chk("reset_no_pulses", c_start + c_stop + c_rise + c_rxv + c_ackv + c_to, 0);
    rst = 1'b0; tick(3);

    // START, 0xA5, ACK, STOP
    b_start = c_start; b_stop = c_stop; b_rise = c_rise; b_rxv = c_rxv; b_ackv = c_ackv;
    bus_start();
    chk("a5_busy_after_start", busBusy, 1);
    send_byte(8'hA5, 1'b0, 1'b0);
    bus_stop(); tick(2);
    chk("a5_rxbyte", rxByte, 8'hA5);
    chk("a5_ackbit", ackBit, 0);
    chk("a5_busy_after_stop", busBusy, 0);
    chk("a5_start_cnt", c_start - b_start, 1);
    chk("a5_stop_cnt", c_stop - b_stop, 1);
    chk("a5_rise_cnt", c_rise - b_rise, 10);
    chk("a5_rxv_cnt", c_rxv - b_rxv, 1);
    chk("a5_ackv_cnt", c_ackv - b_ackv, 1);

    // Partial byte cut by repeated START, then 0x3C with NACK
    b_start = c_start; b_rxv = c_rxv;
    bus_start();
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    chk("rs_no_partial_rxv", c_rxv - b_rxv, 0);
    bus_start();
    send_byte(8'h3C, 1'b1, 1'b0);
    bus_stop(); tick(2);
    chk("rs_start_cnt", c_start - b_start, 2);
    chk("rs_rxv_cnt", c_rxv - b_rxv, 1);
    chk("rs_rxbyte", rxByte, 8'h3C);
    chk("rs_ackbit", ackBit, 1);

    // SDA activity while SCL low, idle and mid-byte
    b_start = c_start; b_stop = c_stop;
    scl = 1'b0; tick(2);
    sda = 1'b0; tick(1); sda = 1'b1; tick(1); sda = 1'b0; tick(1); sda = 1'b1; tick(1);
    scl = 1'b1; tick(3);
    chk("glitch_idle_no_cond", (c_start - b_start) + (c_stop - b_stop), 0);
    chk("glitch_idle_busy", busBusy, 0);
    bus_start();
    send_byte(8'h96, 1'b0, 1'b1);
    bus_stop(); tick(2);
    chk("glitch_data_start_cnt", c_start - b_start, 1);
    chk("glitch_data_stop_cnt", c_stop - b_stop, 1);
    chk("glitch_data_rxbyte", rxByte, 8'h96);

`ifdef I2C_BUS_TIMEOUT_EN
    // SCL stuck low mid-transfer
    b_to = c_to; b_rxv = c_rxv;
    bus_start();
    tick(TO + 4);
    chk("to_pulse_cnt", c_to - b_to, 1);
    chk("to_busy_at_pulse", to_busy, 0);
    chk("to_busy_after", busBusy, 0);
    bus_start();
    send_byte(8'h5A, 1'b0, 1'b0);
    bus_stop(); tick(2);
    chk("to_next_rxbyte", rxByte, 8'h5A);
    chk("to_next_rxv_cnt", c_rxv - b_rxv, 1);
`else
    b_to = c_to;
`endif

    // Reset mid-byte, then a clean 0xFF transfer
    bus_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    rst = 1'b1; tick(1);
    chk("midrst_outputs",
        {15'd0, startDetected, stopDetected, sclRise, sclFall, rxValid, rxByte,
         ackValid, ackBit, busBusy, busTimeout}, 32'd0);
    rst = 1'b0; tick(2);
    b_rxv = c_rxv; b_ackv = c_ackv;
    bus_start();
    send_byte(8'hFF, 1'b0, 1'b0);
    bus_stop(); tick(2);
    chk("midrst_rxbyte", rxByte, 8'hFF);
    chk("midrst_ackbit", ackBit, 0);
    chk("midrst_rxv_cnt", c_rxv - b_rxv, 1);
    chk("midrst_ackv_cnt", c_ackv - b_ackv, 1);
    chk("no_stray_timeout", c_to - b_to, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
